// File: rtl/jump_result_unit.sv
// jump_result_unit
// Turns completed jump-FU operations into a one-cycle fetch redirect and
// queues link-register writebacks for JAL/JALR with rd != 0.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   finish               FU result-valid strobe (one cycle per operation)
//   cmp_res, uncond      branch condition / unconditional-jump flag
//   PC_jump, PC_wb, rd   target address, link value, destination register
//   wb_grant             writeback-bus grant for the queue head
//   wb_req/wb_rd/wb_data head of the writeback queue
//   redirect_valid/pc    registered redirect pulse and target
//   fu_stall             queue full; upstream must hold off issue
//   overflow             sticky: an entry was dropped while full
//   taken_cnt            number of redirects issued (wraps)
module jump_result_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        finish,
    input  logic        cmp_res,
    input  logic [31:0] PC_jump,
    input  logic [31:0] PC_wb,
    input  logic        uncond,
    input  logic [4:0]  rd,
    input  logic        wb_grant,
    output logic        wb_req,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        fu_stall,
    output logic        overflow,
    output logic [31:0] taken_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = AW'(DEPTH) == '0 ? (AW+1)'(DEPTH) : (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic taken;
    logic push_req;
    logic pop;
    logic full;
    logic push;

    assign taken    = finish & (uncond | cmp_res);
    assign push_req = finish & uncond & (rd != 5'd0);
    assign full     = (count == FULL_CNT);
    assign wb_req   = (count != '0);
    assign pop      = wb_req & wb_grant;
    // A same-cycle pop frees the head slot, so a push into a full queue is
    // accepted; when full, wr_ptr == rd_ptr and the popped slot is reused.
    assign push     = push_req & (~full | pop);

    assign wb_rd    = mem_rd[rd_ptr];
    assign wb_data  = mem_data[rd_ptr];
    assign fu_stall = full;

    // Storage carries no reset: wb_req gates its validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= rd;
            mem_data[wr_ptr] <= PC_wb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
            if (push_req && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Redirect path is independent of the queue so a full queue never
    // delays a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            taken_cnt      <= 32'd0;
        end else begin
            redirect_valid <= taken;
            if (taken) begin
                redirect_pc <= PC_jump;
                taken_cnt   <= taken_cnt + 32'd1;
            end
        end
    end

endmodule
